// File: rtl/seg7_pkg.sv
// Shared definitions for the multiplexed 7-segment driver: active-low segment
// patterns ({g,f,e,d,c,b,a}), the converter state type and BCD sizing helper.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_E     = 7'b0000110;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } conv_state_t;

    // Decimal digits needed for a bin_w-bit magnitude (log10(2) ~ 0.31).
    function automatic int n_bcd(input int bin_w);
        return (bin_w * 31) / 100 + 1;
    endfunction

    function automatic logic [6:0] seg_digit(input logic [3:0] d);
        case (d)
            4'd0:    seg_digit = SEG_0;
            4'd1:    seg_digit = SEG_1;
            4'd2:    seg_digit = SEG_2;
            4'd3:    seg_digit = SEG_3;
            4'd4:    seg_digit = SEG_4;
            4'd5:    seg_digit = SEG_5;
            4'd6:    seg_digit = SEG_6;
            4'd7:    seg_digit = SEG_7;
            4'd8:    seg_digit = SEG_8;
            4'd9:    seg_digit = SEG_9;
            default: seg_digit = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/seg7_mux_driver_bin2bcd.sv
// Sequential double-dabble converter: one add-3/shift step per clock, BIN_W
// steps per conversion. done flags the cycle in which the final step happens.
module bin2bcd_seq
    import seg7_pkg::*;
#(
    parameter int BIN_W = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [BIN_W-1:0]            bin,
    output logic                        busy,
    output logic                        done,
    output logic [4*n_bcd(BIN_W)-1:0]   bcd
);

    localparam int N_BCD = n_bcd(BIN_W);
    localparam int BCD_W = 4 * N_BCD;
    localparam int CNT_W = $clog2(BIN_W + 1);

    logic [BIN_W-1:0] sh_q;
    logic [BCD_W-1:0] bcd_q;
    logic [BCD_W-1:0] adj_p0;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;

    function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        r = v;
        for (int k = 0; k < N_BCD; k++) begin
            if (r[4*k +: 4] >= 4'd5) r[4*k +: 4] = r[4*k +: 4] + 4'd3;
        end
        return r;
    endfunction

    always_comb adj_p0 = dabble_adjust(bcd_q);

    // ---- stage boundary: step registers ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            sh_q   <= '0;
            bcd_q  <= '0;
        end else if (start && !busy_q) begin
            busy_q <= 1'b1;
            cnt_q  <= CNT_W'(BIN_W);
            sh_q   <= bin;
            bcd_q  <= '0;
        end else if (busy_q) begin
            bcd_q <= {adj_p0[BCD_W-2:0], sh_q[BIN_W-1]};
            sh_q  <= {sh_q[BIN_W-2:0], 1'b0};
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) busy_q <= 1'b0;
        end
    end

    assign busy = busy_q;
    assign done = busy_q && (cnt_q == CNT_W'(1));
    assign bcd  = bcd_q;

endmodule

// File: rtl/seg7_mux_driver.sv
// Signed-magnitude to multiplexed common-anode 7-segment driver with
// leading-zero blanking, floating minus sign and overflow 'E' display.
module seg7_mux_driver
    import seg7_pkg::*;
#(
    parameter int BIN_W       = 8,
    parameter int N_DIGITS    = 4,
    parameter int REFRESH_DIV = 262144
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_valid,
    output logic                load_ready,
    input  logic [BIN_W-1:0]    bin,
    input  logic                sgn,
    input  logic                blank_lz,
    output logic [N_DIGITS-1:0] disp_select,
    output logic [7:0]          disp_value,
    output logic                overflow
);

    localparam int N_BCD   = n_bcd(BIN_W);
    localparam int BCD_W   = 4 * N_BCD;
    localparam int IDX_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int PRESC_W = $clog2(REFRESH_DIV);
    localparam logic [IDX_W-1:0]   TOP_IDX  = IDX_W'(N_DIGITS - 1);
    localparam logic [PRESC_W-1:0] PRESC_TC = PRESC_W'(REFRESH_DIV - 1);

    conv_state_t        state_q, state_d;
    logic               conv_start, conv_busy, conv_done, commit;
    logic [BCD_W-1:0]   conv_bcd;
    logic               sgn_cap;
    logic [BCD_W-1:0]   shown_bcd;
    logic               shown_sign;
    logic               overflow_q;
    logic [PRESC_W-1:0] presc_q;
    logic [IDX_W-1:0]   digit_idx;
    logic [IDX_W-1:0]   msd_p0;
    logic [3:0]         nib_p0;
    logic [6:0]         seg_p0;

    function automatic logic [3:0] nib_at(input logic [BCD_W-1:0] v, input int idx);
        nib_at = 4'h0;
        for (int k = 0; k < N_BCD; k++) begin
            if (k == idx) nib_at = v[4*k +: 4];
        end
    endfunction

    // Any nonzero nibble that has no magnitude digit to land on.
    function automatic logic bcd_overflow(input logic [BCD_W-1:0] v);
        bcd_overflow = 1'b0;
        for (int k = N_DIGITS - 1; k < N_BCD; k++) begin
            if (v[4*k +: 4] != 4'h0) bcd_overflow = 1'b1;
        end
    endfunction

    bin2bcd_seq #(
        .BIN_W (BIN_W)
    ) u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start),
        .bin   (bin),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        load_ready = 1'b0;
        conv_start = 1'b0;
        commit     = 1'b0;
        case (state_q)
            IDLE: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    conv_start = 1'b1;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                if (conv_done || !conv_busy) state_d = COMMIT;
            end
            COMMIT: begin
                commit  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ---- stage boundary: captured sign and atomically committed display value ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sgn_cap    <= 1'b0;
            shown_bcd  <= '0;
            shown_sign <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (conv_start) sgn_cap <= sgn;
            if (commit) begin
                shown_bcd  <= conv_bcd;
                shown_sign <= sgn_cap && (conv_bcd != '0);
                overflow_q <= bcd_overflow(conv_bcd);
            end
        end
    end

    assign overflow = overflow_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q   <= '0;
            digit_idx <= '0;
        end else if (presc_q == PRESC_TC) begin
            presc_q   <= '0;
            digit_idx <= (digit_idx == TOP_IDX) ? '0 : digit_idx + IDX_W'(1);
        end else begin
            presc_q <= presc_q + PRESC_W'(1);
        end
    end

    always_comb begin
        msd_p0 = '0;
        for (int k = 1; k < N_DIGITS - 1; k++) begin
            if (nib_at(shown_bcd, k) != 4'h0) msd_p0 = IDX_W'(k);
        end
        nib_p0 = nib_at(shown_bcd, int'(digit_idx));
        seg_p0 = SEG_BLANK;
        if (overflow_q) begin
            seg_p0 = SEG_E;
        end else if (!blank_lz) begin
            if (digit_idx == TOP_IDX) seg_p0 = shown_sign ? SEG_MINUS : SEG_BLANK;
            else                      seg_p0 = seg_digit(nib_p0);
        end else begin
            // The sign floats to the position just left of the most significant digit.
            if (digit_idx <= msd_p0)                                seg_p0 = seg_digit(nib_p0);
            else if (shown_sign && digit_idx == msd_p0 + IDX_W'(1)) seg_p0 = SEG_MINUS;
        end
    end

    // ---- stage boundary: registered anode select and segment drive ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_select <= '1;
            disp_value  <= 8'hFF;
        end else begin
            disp_select <= ~(N_DIGITS'(1) << digit_idx);
            disp_value  <= {1'b1, seg_p0};
        end
    end

endmodule

// File: tb/tb_seg7_mux_driver.sv
// Scoreboard bench for seg7_mux_driver: expected digit patterns are queued at
// load time from an arithmetic decimal model and popped when a frame is scanned.
module tb_seg7_mux_driver;

    localparam int BIN_W = 8;
    localparam int RDIV  = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       load_valid4, load_valid3;
    logic       ready4, ready3;
    logic [7:0] bin;
    logic       sgn, blank_lz;
    logic [3:0] sel4;
    logic [2:0] sel3;
    logic [7:0] val4, val3;
    logic       ovf4, ovf3;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    seg7_mux_driver #(.BIN_W(BIN_W), .N_DIGITS(4), .REFRESH_DIV(RDIV)) dut4 (
        .clk(clk), .rst(rst), .load_valid(load_valid4), .load_ready(ready4),
        .bin(bin), .sgn(sgn), .blank_lz(blank_lz),
        .disp_select(sel4), .disp_value(val4), .overflow(ovf4)
    );

    seg7_mux_driver #(.BIN_W(BIN_W), .N_DIGITS(3), .REFRESH_DIV(RDIV)) dut3 (
        .clk(clk), .rst(rst), .load_valid(load_valid3), .load_ready(ready3),
        .bin(bin), .sgn(sgn), .blank_lz(blank_lz),
        .disp_select(sel3), .disp_value(val3), .overflow(ovf3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] digit_pat(input int n);
        case (n)
            0: return 8'hC0;
            1: return 8'hF9;
            2: return 8'hA4;
            3: return 8'hB0;
            4: return 8'h99;
            5: return 8'h92;
            6: return 8'h82;
            7: return 8'hF8;
            8: return 8'h80;
            default: return 8'h90;
        endcase
    endfunction

    function automatic logic [7:0] model_seg(input int value, input bit neg, input bit blz,
                                             input int ndig, input int d);
        int p10;
        int nd;
        int tmp;
        int digit;
        p10 = 1;
        for (int k = 0; k < ndig - 1; k++) p10 = p10 * 10;
        if (value >= p10) return 8'h86;
        tmp = value;
        for (int k = 0; k < d; k++) tmp = tmp / 10;
        digit = tmp % 10;
        nd = 1;
        tmp = value / 10;
        while (tmp > 0) begin
            nd++;
            tmp = tmp / 10;
        end
        if (!blz) begin
            if (d == ndig - 1) return (neg && value != 0) ? 8'hBF : 8'hFF;
            return digit_pat(digit);
        end
        if (d < nd) return digit_pat(digit);
        if (d == nd && neg && value != 0) return 8'hBF;
        return 8'hFF;
    endfunction

    task automatic push_frame(input int value, input bit neg, input bit blz, input int ndig);
        for (int d = 0; d < ndig; d++) exp_q.push_back(model_seg(value, neg, blz, ndig, d));
    endtask

    task automatic scan(input bit which3, input string tag);
        logic [7:0] seen [4];
        logic [3:0] s;
        int ndig;
        ndig = which3 ? 3 : 4;
        for (int d = 0; d < 4; d++) seen[d] = 8'h00;
        repeat (ndig * RDIV + 4) begin
            @(negedge clk);
            s = which3 ? {1'b1, sel3} : sel4;
            for (int d = 0; d < ndig; d++) begin
                if (s == ~(4'b0001 << d)) seen[d] = which3 ? val3 : val4;
            end
        end
        for (int d = 0; d < ndig; d++) begin
            if (exp_q.size() == 0) check($sformatf("%s_sb_empty", tag), 1, 0);
            else check($sformatf("%s_d%0d", tag, d), {24'h0, seen[d]}, {24'h0, exp_q.pop_front()});
        end
    endtask

    // Loads a value, optionally pulses a stray load (bin=45) at the given busy cycle,
    // and checks how long load_ready stays low.
    task automatic load(input bit which3, input int value, input bit neg, input bit blz,
                        input int inject_at, input string tag);
        int lowcnt;
        int guard;
        lowcnt = 0;
        guard  = 0;
        @(negedge clk);
        while (!(which3 ? ready3 : ready4) && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        bin = 8'(value);
        sgn = neg;
        blank_lz = blz;
        if (which3) load_valid3 = 1'b1; else load_valid4 = 1'b1;
        push_frame(value, neg, blz, which3 ? 3 : 4);
        @(negedge clk);
        load_valid3 = 1'b0;
        load_valid4 = 1'b0;
        bin = ~bin;
        sgn = ~neg;
        guard = 0;
        while (!(which3 ? ready3 : ready4) && guard < 50) begin
            lowcnt++;
            if (lowcnt == inject_at) begin
                bin = 8'd45;
                if (which3) load_valid3 = 1'b1; else load_valid4 = 1'b1;
            end
            @(negedge clk);
            load_valid3 = 1'b0;
            load_valid4 = 1'b0;
            guard++;
        end
        check({tag, "_lat"}, lowcnt, 9);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int slot_hits;
        logic [3:0] samples [16];

        rst = 1'b1;
        load_valid4 = 1'b0;
        load_valid3 = 1'b0;
        bin = '0;
        sgn = 1'b0;
        blank_lz = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (7) @(negedge clk);

        // Asynchronous reset asserted mid-run
        #2 rst = 1'b1;
        #1;
        check("rst_ready", ready4, 1);
        check("rst_ovf", ovf4, 0);
        check("rst_sel", sel4, 4'b1111);
        check("rst_val", val4, 8'hFF);
        check("rst_sel3", sel3, 3'b111);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            samples[k] = sel4;
        end
        for (int d = 0; d < 4; d++) begin
            slot_hits = 0;
            for (int k = 4 * d; k < 4 * d + 4; k++) begin
                if (samples[k] == ~(4'b0001 << d)) slot_hits++;
            end
            check($sformatf("cycle_slot%0d", d), slot_hits, 4);
        end

        push_frame(0, 1'b0, 1'b0, 4);
        scan(1'b0, "rst_frame");

        load(1'b0, 123, 1'b0, 1'b0, -1, "v123");
        scan(1'b0, "v123");
        check("v123_ovf", ovf4, 0);

        load(1'b0, 7, 1'b1, 1'b1, -1, "v7neg");
        scan(1'b0, "v7neg");

        load(1'b0, 0, 1'b1, 1'b1, -1, "v0neg");
        scan(1'b0, "v0neg");

        load(1'b0, 200, 1'b0, 1'b0, 3, "v200");
        scan(1'b0, "v200");
        check("v200_ready", ready4, 1);

        load(1'b1, 255, 1'b0, 1'b0, -1, "n3_255");
        scan(1'b1, "n3_255");
        check("n3_255_ovf", ovf3, 1);

        load(1'b1, 42, 1'b0, 1'b1, -1, "n3_42");
        scan(1'b1, "n3_42");
        check("n3_42_ovf", ovf3, 0);

        // Reset in the middle of converting 99
        @(negedge clk);
        bin = 8'd99;
        sgn = 1'b0;
        blank_lz = 1'b0;
        load_valid4 = 1'b1;
        @(negedge clk);
        load_valid4 = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_ready", ready4, 1);
        check("abort_val", val4, 8'hFF);
        @(negedge clk);
        rst = 1'b0;
        push_frame(0, 1'b0, 1'b0, 4);
        scan(1'b0, "abort");

        load(1'b0, 5, 1'b0, 1'b0, -1, "v5");
        scan(1'b0, "v5");

        check("sb_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_mux_driver.md
Name: seg7_mux_driver

Overview:
- Parametrised successor to the board's 4-digit 7-segment decoder.
- Accepts a signed-magnitude binary value through a valid/ready handshake and converts it to BCD sequentially, one double-dabble step per clock.
- Time-multiplexes N_DIGITS common-anode digits with a configurable refresh divider.
- Adds optional leading-zero blanking with a floating minus sign, and overflow indication.
- Sits between the calculator datapath result register and the board display pins.

Parameters:
- BIN_W, 8, magnitude input width in bits.
- N_DIGITS, 4, physical digits; one is reserved for the sign, so N_DIGITS-1 are magnitude digits.
- REFRESH_DIV, 262144, clk cycles each digit stays selected (must be >= 2).

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- load_valid  in  1  new value offered
- load_ready  out  1  converter idle, can accept
- bin  in  BIN_W  unsigned magnitude
- sgn  in  1  1 = negative
- blank_lz  in  1  1 = suppress leading zeros (sampled live)
- disp_select  out  N_DIGITS  digit anodes, active low, one-hot-low
- disp_value  out  8  {dp, g, f, e, d, c, b, a}, active low
- overflow  out  1  displayed value exceeds magnitude digits

Behaviour:
- Reset is rst, asynchronous, active-high; the clock is clk.
- Reset values:
  - load_ready=1, overflow=0
  - disp_select = all 1s, disp_value = 8'hFF
  - shown value = 0, shown sign = 0
  - prescaler = 0, digit index = 0
- Conversion FSM:
  - IDLE: load_ready=1. On load_valid & load_ready, capture bin and sgn, clear BCD, go to SHIFT.
  - SHIFT: exactly BIN_W cycles. Each cycle adds 3 to every BCD nibble >= 5, then shifts in the next bin MSB. load_ready=0.
  - COMMIT: one cycle. Atomically copy BCD to the shown register, set overflow, latch sign. Return to IDLE.
- Latency: accept at edge T; the shown register is updated at edge T+BIN_W+1; load_ready is high again from T+BIN_W+1.
- load_valid while load_ready=0 is ignored; no queueing.
- Internal BCD width is 4*N_BCD, where N_BCD = (BIN_W*31)/100+1.
- overflow=1 if any BCD nibble at index >= N_DIGITS-1 is nonzero. While overflow=1, every digit shows 'E' (7'b0000110).
- Refresh:
  - Prescaler counts 0..REFRESH_DIV-1.
  - At the terminal count the digit index advances, wrapping N_DIGITS-1 -> 0.
  - Digit 0 is rightmost (units).
- disp_select and disp_value are registered from the current index and shown register, with 1 cycle delay. Exactly one disp_select bit is low after the first post-reset edge.
- Digit content when not in overflow:
  - Index N_DIGITS-1 shows '-' (7'b0111111) if sign=1, else blank (7'b1111111).
  - Other indices show the decimal pattern of their nibble.
- blank_lz=1:
  - Zeros above the most significant nonzero digit are blank.
  - The digit immediately left of the MSD shows '-' when sign=1; the top digit is then blank unless it is that position.
  - The units digit is never blanked.
- Value 0 with sgn=1 shows no minus sign.
- dp (bit 7) is always 1 (off).
- A COMMIT coinciding with an index advance: the new digit uses the new value. No mixed old/new frame within one digit slot.
- rst mid-conversion aborts the conversion and returns all state to the reset values.

Decomposition:
- Package seg7_pkg:
  - segment constants SEG_0..SEG_9, SEG_MINUS, SEG_BLANK, SEG_E
  - function n_bcd(bin_w)
  - FSM state enum {IDLE, SHIFT, COMMIT}
- Sub-module bin2bcd_seq: sequential double-dabble.
  - Ports: clk, rst, start, bin, busy, done, bcd.
  - The top level owns the handshake, the shown register, overflow/blanking, and the refresh multiplexer.

Test Plan (BIN_W=8, N_DIGITS=4, REFRESH_DIV=4 unless stated):
- Reset: assert rst mid-run -> load_ready=1, overflow=0, disp_select=4'b1111, disp_value=8'hFF. After release, digits cycle 0,1,2,3 with 4 cycles each; blank_lz=0 shows "0000" minus the sign digit, which is blank.
- Load 123, sgn=0, blank_lz=0 -> load_ready low 9 cycles. Then per select:
  - 1110: 8'hB0 ('3')
  - 1101: 8'hA4 ('2')
  - 1011: 8'hF9 ('1')
  - 0111: 8'hFF
- Load 7, sgn=1, blank_lz=1 -> digit0 8'hF8 ('7'), digit1 8'hBF ('-'), digits 2 and 3 8'hFF. Load 0, sgn=1 -> digit0 8'hC0, all others 8'hFF.
- Pulse load_valid with 45 at cycle 3 of a conversion of 200 -> ignored; display ends at "200", and 45 never appears.
- N_DIGITS=3 instance, load 255 -> overflow=1, all three digits 8'h86 ('E'). Then load 42 -> overflow=0, display " 42".
- Assert rst during SHIFT of 99 -> conversion aborted, display stays 0, the next load of 5 completes normally in 9 cycles.
